// File: rtl/nabp_pkg.sv
// Shared constants and types for the NABP projection datapath.
package nabp_pkg;

  localparam int kFilteredDataLength = 16;
  localparam int kLineLength         = 256;
  localparam int kFirDelay           = 32;

  typedef enum logic [1:0] {
    WR_SKIP = 2'd0,
    WR_FILL = 2'd1,
    WR_HOLD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/nabp_line_ram.sv
// Simple dual-port line RAM with a registered read port.
// The bank select is the address MSB, so the array holds both ping-pong banks.
module nabp_line_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Sized from the address width so the bank MSB always lands in range.
  // This equals 2*LINE_LENGTH whenever the line length is a power of two.
  localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: no reset, so block RAM can be inferred.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read: the output holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/filtered_line_buffer.sv
// Ping-pong line buffer for the filtered projection stream.
// The filter's group delay is dropped at the start of each line. The next
// LINE_LENGTH samples fill the write bank. The banks then swap, and the
// consumer reads the completed line at its own pace.
//
// state | meaning
// SKIP  | discarding FIR_DELAY leading samples of a new line
// FILL  | writing accepted samples into the write bank
// HOLD  | write bank full, waiting for the consumer to release the read bank
module filtered_line_buffer
  import nabp_pkg::*;
#(
  parameter int DATA_WIDTH  = kFilteredDataLength,
  parameter int LINE_LENGTH = kLineLength,
  parameter int ADDR_WIDTH  = $clog2(kLineLength),
  parameter int FIR_DELAY   = kFirDelay
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  line_ready,
  input  logic                  line_done,
  output logic [15:0]           line_index
);

  localparam int SKIP_W = (FIR_DELAY > 1) ? $clog2(FIR_DELAY) : 1;
  localparam logic [SKIP_W-1:0]   SKIP_LAST    = SKIP_W'(FIR_DELAY - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LINE_LENGTH - 1);
  localparam logic [ADDR_WIDTH:0] LINE_LEN_EXT = (ADDR_WIDTH + 1)'(LINE_LENGTH);

  wr_state_e             state;
  wr_state_e             state_nxt;
  logic [SKIP_W-1:0]     skip_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_bank;

  logic accept;
  logic fill_active;
  logic fill_accept;
  logic skip_accept;
  logic skip_last;
  logic line_last;
  logic swap;
  logic ram_rd_en;

  assign accept      = in_valid && in_ready;
  assign fill_accept = accept && fill_active;
  assign skip_accept = accept && (state == WR_SKIP) && (FIR_DELAY != 0);
  assign skip_last   = skip_accept && (skip_cnt == SKIP_LAST);
  assign line_last   = fill_accept && (wr_addr == LAST_ADDR);
  // A full line swaps immediately unless the consumer still holds the read bank.
  // A release in the same cycle counts as free.
  assign swap        = (line_last && !(line_ready && !line_done)) ||
                       ((state == WR_HOLD) && line_done);
  // Out-of-range read addresses leave rd_data untouched.
  assign ram_rd_en   = rd_en && ({1'b0, rd_addr} < LINE_LEN_EXT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= WR_SKIP;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      WR_SKIP: begin
        if (FIR_DELAY == 0) begin
          if (line_last) state_nxt = swap ? WR_SKIP : WR_HOLD;
          else           state_nxt = WR_FILL;
        end else if (skip_last) begin
          state_nxt = WR_FILL;
        end
      end
      WR_FILL: begin
        if (line_last) state_nxt = swap ? WR_SKIP : WR_HOLD;
      end
      WR_HOLD: begin
        if (line_done) state_nxt = WR_SKIP;
      end
      default: state_nxt = WR_SKIP;
    endcase
  end

  // FSM outputs. With no group delay, SKIP already behaves as FILL.
  always_comb begin
    in_ready    = !reset && (state != WR_HOLD);
    fill_active = (state == WR_FILL) || ((state == WR_SKIP) && (FIR_DELAY == 0));
  end

  // Skip and write-address counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt <= '0;
      wr_addr  <= '0;
    end else begin
      if (skip_last)        skip_cnt <= '0;
      else if (skip_accept) skip_cnt <= skip_cnt + 1'b1;
      if (fill_accept)      wr_addr  <= line_last ? '0 : wr_addr + 1'b1;
    end
  end

  // Bank select, line handshake and line sequence number.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank    <= 1'b0;
      line_ready <= 1'b0;
      line_index <= 16'd0;
    end else if (swap) begin
      wr_bank    <= ~wr_bank;
      line_ready <= 1'b1;
      line_index <= line_index + 16'd1;
    end else if (line_done && line_ready && (state != WR_HOLD)) begin
      line_ready <= 1'b0;
    end
  end

  nabp_line_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (fill_accept),
    .wr_addr({wr_bank, wr_addr}),
    .wr_data(in_data),
    .rd_en  (ram_rd_en),
    .rd_addr({~wr_bank, rd_addr}),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_filtered_line_buffer.sv
// Testbench for filtered_line_buffer (LINE_LENGTH=8, FIR_DELAY=2).
module tb_filtered_line_buffer;

  localparam int DW = 16;
  localparam int LL = 8;
  localparam int AW = 3;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          line_ready;
  logic          line_done;
  logic [15:0]   line_index;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  filtered_line_buffer #(
    .DATA_WIDTH (DW),
    .LINE_LENGTH(LL),
    .ADDR_WIDTH (AW),
    .FIR_DELAY  (FD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .line_ready(line_ready),
    .line_done (line_done),
    .line_index(line_index)
  );

  // Reference model: accepted samples of the line in progress (leading
  // group-delay samples included), the last published line, and handshake flags.
  logic [DW-1:0] m_cur[$];
  logic [DW-1:0] m_line[LL];
  bit            m_line_valid;
  bit            m_hold;
  bit            m_ready;
  logic [15:0]   m_index;
  logic [DW-1:0] m_rd;
  bit            m_rd_known;

  function automatic void model_reset();
    m_cur.delete();
    m_line_valid = 0;
    m_hold       = 0;
    m_ready      = 0;
    m_index      = 16'd0;
    m_rd         = '0;
    m_rd_known   = 1;
  endfunction

  function automatic void model_publish();
    for (int i = 0; i < LL; i++) m_line[i] = m_cur[FD + i];
    m_line_valid = 1;
    m_ready      = 1;
    m_index      = m_index + 16'd1;
    m_hold       = 0;
    m_cur.delete();
  endfunction

  function automatic void model_step(bit v, logic [DW-1:0] d, bit done, bit rden,
                                     logic [AW-1:0] raddr);
    logic [DW-1:0] rd_exp;
    bit rd_ok;
    bit acc;
    rd_exp = m_line[raddr];
    rd_ok  = m_line_valid;
    acc    = v && !m_hold;
    if (m_hold) begin
      if (done) model_publish();
    end else begin
      if (acc) m_cur.push_back(d);
      if (acc && m_cur.size() == FD + LL) begin
        if (m_ready && !done) m_hold = 1;
        else                  model_publish();
      end else if (done && m_ready) begin
        m_ready = 0;
      end
    end
    if (rden) begin
      m_rd_known = rd_ok;
      m_rd       = rd_exp;
    end
  endfunction

  // One clock cycle: drive inputs, check in_ready before the edge, then check
  // the registered outputs just after the edge against the model.
  task automatic cycle(bit v, logic [DW-1:0] d, bit done, bit rden, logic [AW-1:0] raddr);
    in_valid  = v;
    in_data   = d;
    line_done = done;
    rd_en     = rden;
    rd_addr   = raddr;
    #1;
    n_cmp++;
    if (in_ready !== !m_hold) begin
      n_err++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, !m_hold, $time);
    end
    @(posedge clk);
    model_step(v, d, done, rden, raddr);
    #1;
    n_cmp++;
    if (line_ready !== m_ready) begin
      n_err++;
      $display("FAIL line_ready: got %b expected %b at %0t", line_ready, m_ready, $time);
    end
    n_cmp++;
    if (line_index !== m_index) begin
      n_err++;
      $display("FAIL line_index: got %0d expected %0d at %0t", line_index, m_index, $time);
    end
    if (m_rd_known) begin
      n_cmp++;
      if (rd_data !== m_rd) begin
        n_err++;
        $display("FAIL rd_data: got %0h expected %0h at %0t", rd_data, m_rd, $time);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_data   = DW'($urandom);
      line_done = 1'b1;
      rd_en     = 1'b1;
      rd_addr   = AW'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      n_cmp++;
      if (line_ready !== 1'b0 || line_index !== 16'd0) begin
        n_err++;
        $display("FAIL reset_line: got ready=%b index=%0d expected 0/0", line_ready, line_index);
      end
      n_cmp++;
      if (rd_data !== '0) begin
        n_err++;
        $display("FAIL reset_rd_data: got %0h expected 0", rd_data);
      end
    end
    model_reset();
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    line_done = 1'b0;
    rd_en     = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic stream(int first, int last, int done_at);
    for (int i = first; i <= last; i++) cycle(1'b1, DW'(i), (i == done_at), 1'b0, '0);
  endtask

  // Read a whole line and compare each word to base+addr as well as the model.
  task automatic read_line(int base, string name);
    for (int a = 0; a < LL; a++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, AW'(a));
      n_cmp++;
      if (rd_data !== DW'(base + a)) begin
        n_err++;
        $display("FAIL %s addr%0d: got %0d expected %0d", name, a, rd_data, base + a);
      end
    end
    // With rd_en low the output must hold the last word read.
    cycle(1'b0, '0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (rd_data !== DW'(base + LL - 1)) begin
      n_err++;
      $display("FAIL %s hold: got %0d expected %0d", name, rd_data, base + LL - 1);
    end
  endtask

  task automatic expect_line(bit rdy, int idx, string name);
    n_cmp++;
    if (line_ready !== rdy || line_index !== 16'(idx)) begin
      n_err++;
      $display("FAIL %s: got ready=%b index=%0d expected ready=%b index=%0d",
               name, line_ready, line_index, rdy, idx);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    expect_line(1'b0, 0, "reset_state");
  endtask

  task automatic test_first_line();
    stream(0, 8, -1);
    expect_line(1'b0, 0, "first_line_before_last");
    stream(9, 9, -1);
    expect_line(1'b1, 1, "first_line_done");
    read_line(2, "first_line_read");
  endtask

  task automatic test_hold();
    stream(10, 19, -1);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL hold_in_ready: got %b expected 0", in_ready);
    end
    cycle(1'b1, DW'(99), 1'b0, 1'b0, '0);
    cycle(1'b1, DW'(98), 1'b1, 1'b0, '0);
    expect_line(1'b1, 2, "hold_release");
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release_in_ready: got %b expected 1", in_ready);
    end
    read_line(12, "hold_line_read");
  endtask

  task automatic test_done_coincide();
    stream(20, 29, 29);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL coincide_in_ready: got %b expected 1", in_ready);
    end
    expect_line(1'b1, 3, "coincide_swap");
    read_line(22, "coincide_line_read");
  endtask

  task automatic test_reset_midline();
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    expect_line(1'b0, 3, "release_clears_ready");
    stream(30, 36, -1);
    do_reset(1);
    expect_line(1'b0, 0, "midline_reset");
    stream(40, 49, -1);
    expect_line(1'b1, 1, "after_reset_line");
    read_line(42, "after_reset_read");
  endtask

  task automatic test_random();
    logic [15:0] idx_before;
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    idx_before = line_index;
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    expect_line(1'b0, int'(idx_before), "done_while_not_ready");
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 11) == 0,
            $urandom_range(0, 1) == 1, AW'($urandom));
    end
    for (int a = 0; a < LL; a++) cycle(1'b0, '0, 1'b0, 1'b1, AW'(a));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    line_done = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    model_reset();
    test_reset();
    test_first_line();
    test_hold();
    test_done_coincide();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/filtered_line_buffer.md
FILTERED_LINE_BUFFER -- requirements
Module: filtered_line_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one filtered sample (equals kFilteredDataLength).
REQ-002 SHALL have parameter LINE_LENGTH, default 256, number of stored samples per projection line.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, which SHALL equal clog2(LINE_LENGTH).
REQ-004 SHALL have parameter FIR_DELAY, default 32, number of leading filter-output samples discarded per line (group delay).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: filtered sample stream.
REQ-009 SHALL have port in_ready, output, 1 bit: sample is accepted when in_valid && in_ready.
REQ-010 SHALL have port rd_en, input, 1 bit: read strobe.
REQ-011 SHALL have port rd_addr, input, ADDR_WIDTH bits: sample index in the read bank.
REQ-012 SHALL have port rd_data, output, DATA_WIDTH bits: read result.
REQ-013 SHALL have port line_ready, output, 1 bit: read bank holds a complete line.
REQ-014 SHALL have port line_done, input, 1 bit: consumer releases the read bank.
REQ-015 SHALL have port line_index, output, 16 bits: sequence number of the line in the read bank.

Function
REQ-016 SHALL hold two banks (ping-pong) of LINE_LENGTH x DATA_WIDTH, one write bank and one read bank.
REQ-017 SHALL run a write FSM with states SKIP, FILL and HOLD; SKIP SHALL be entered on reset and after every swap.
REQ-018 In SKIP, SHALL discard FIR_DELAY accepted samples, then go to FILL; if FIR_DELAY=0, SHALL go directly to FILL.
REQ-019 In FILL, SHALL write accepted samples to the write bank at addresses 0..LINE_LENGTH-1; the write address SHALL wrap to 0 when the line completes.
REQ-020 When the sample at address LINE_LENGTH-1 is accepted, SHALL go to HOLD if line_ready=1, else swap banks that cycle.
REQ-021 In HOLD, SHALL drive in_ready=0; on line_done, SHALL swap banks, assert line_ready next cycle and return to SKIP.
REQ-022 A swap SHALL set line_ready=1, increment line_index modulo 2^16, and tag the new read bank with it.
REQ-023 in_ready SHALL be 1 in SKIP and FILL and 0 in HOLD and during reset.
REQ-024 On line_done with line_ready=1 and FSM not in HOLD, SHALL clear line_ready next cycle.
REQ-025 On line_done with line_ready=0, SHALL take no action.
REQ-026 When line_done coincides with acceptance of the last FILL sample, SHALL swap without entering HOLD, and line_ready SHALL remain 1.
REQ-027 Read latency SHALL be 1 cycle: rd_data reflects rd_addr of the previous rd_en cycle; rd_data SHALL hold its value when rd_en=0.
REQ-028 rd_addr >= LINE_LENGTH SHALL return an undefined value and SHALL NOT alter state.
REQ-029 The block SHALL NOT modify sample values; storage width equals DATA_WIDTH, with no truncation.
REQ-030 Reads with line_ready=0 SHALL return stale data and SHALL have no side effects.

Reset
REQ-031 Reset SHALL set: FSM to SKIP, skip/write counters to 0, write bank to 0, line_ready=0, line_index=0, rd_data=0, in_ready=0 during reset and 1 the cycle after.
REQ-032 Reset mid-line or mid-read SHALL abandon all buffered data; RAM contents need not be cleared.
REQ-033 Inputs SHALL be ignored while reset=1.

Structure
REQ-034 Constants kFilteredDataLength, kLineLength and kFirDelay SHALL reside in the shared nabp_pkg / defines and feed the parameter defaults.
REQ-035 Storage SHALL be one sub-module nabp_line_ram (simple dual-port, registered read, 2*LINE_LENGTH deep, bank select as address MSB), inferring block RAM.
REQ-036 The FSM, counters and bank select SHALL reside in filtered_line_buffer.

Verification (LINE_LENGTH=8, FIR_DELAY=2)
REQ-037 Reset, then stream 0..9 continuously -> samples 0,1 dropped; line_ready=1 after sample 9; reads of addr 0..7 return 2..9; line_index=1.
REQ-038 Leave line 1 unreleased and stream 10..19 -> in_ready=0 after 19 is accepted; pulse line_done -> line_ready stays 1, line_index=2, reads return 12..19, in_ready=1 next cycle.
REQ-039 Assert line_done in the same cycle the 8th FILL sample is accepted -> no HOLD (in_ready stays 1), swap occurs, line_index increments.
REQ-040 Apply reset after 5 FILL samples -> line_ready=0, line_index=0; the next line again drops 2 samples before storing.
REQ-041 Toggle in_valid randomly -> stored line equals the accepted samples in order; line_done while line_ready=0 has no effect.
